// File: rtl/pan_pkg.sv
// Package: pan_pkg
// Shared types, widths and the per-frame slew limiter for the pan offset
// controller.
//   state_t   : controller FSM states (IDLE, SLEW, COMMIT)
//   H_OFF_W   : width of the horizontal offset
//   V_OFF_W   : width of the vertical offset
//   CALC_W    : signed intermediate width, wide enough for offset + step
//   sat_step  : clamps a signed difference to [-step_max, +step_max]
package pan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SLEW   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int H_OFF_W = 11;
   localparam int V_OFF_W = 10;
   localparam int CALC_W  = 13;

   function automatic logic signed [CALC_W-1:0] sat_step(
      input logic signed [CALC_W-1:0] diff,
      input int                       step_max
   );
      logic signed [CALC_W-1:0] lim;
      lim = CALC_W'(step_max);
      if (diff > lim)
         return lim;
      else if (diff < -lim)
         return -lim;
      else
         return diff;
   endfunction

endpackage

// File: rtl/pan_axis.sv
// Module: pan_axis
// One axis of the pan controller: accumulates signed steps into a clamped
// target and slews the live offset toward a frame-boundary snapshot of that
// target by at most STEP_MAX per commit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   accept      : a step is taken this cycle
//   recenter    : force target to 0 (wins over accept)
//   snap_en     : capture the current target for the upcoming commit
//   commit_en   : apply one slew step to the live offset
//   step        : signed two's-complement step
//   live        : registered live offset
//   live_nxt    : live offset after this cycle's edge
//   target_nxt  : target after this cycle's edge
module pan_axis
   import pan_pkg::*;
#(
   parameter int W        = 11,
   parameter int MAX_OFF  = 1023,
   parameter int STEP_MAX = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         accept,
   input  logic         recenter,
   input  logic         snap_en,
   input  logic         commit_en,
   input  logic [7:0]   step,
   output logic [W-1:0] live,
   output logic [W-1:0] live_nxt,
   output logic [W-1:0] target_nxt
);

   localparam logic signed [CALC_W-1:0] MAX_S = CALC_W'(MAX_OFF);
   localparam logic [W-1:0]             MAX_U = W'(MAX_OFF);

   logic [W-1:0]             target;
   logic [W-1:0]             snap;
   logic signed [CALC_W-1:0] sum;
   logic signed [CALC_W-1:0] diff;
   logic signed [CALC_W-1:0] delta;

   always_comb begin
      sum        = $signed({{(CALC_W-W){1'b0}}, target})
                 + $signed({{(CALC_W-8){step[7]}}, step});
      diff       = $signed({{(CALC_W-W){1'b0}}, snap})
                 - $signed({{(CALC_W-W){1'b0}}, live});
      delta      = sat_step(diff, STEP_MAX);
      target_nxt = target;
      if (recenter)
         target_nxt = '0;
      else if (accept) begin
         if (sum < 0)
            target_nxt = '0;
         else if (sum > MAX_S)
            target_nxt = MAX_U;
         else
            target_nxt = W'(sum);
      end
      // The commit works from the snapshot, so a step that lands on the
      // frame-tick cycle only affects the following frame.
      live_nxt = commit_en ? live + W'(delta) : live;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target <= '0;
         live   <= '0;
         snap   <= '0;
      end else begin
         target <= target_nxt;
         live   <= live_nxt;
         if (snap_en)
            snap <= target;
      end
   end

endmodule

// File: rtl/pan_offset_controller.sv
// Module: pan_offset_controller
// Accepts pan steps from the gesture decoder, accumulates them into a clamped
// target offset and slews the live h/v offsets toward it by a bounded step
// once per frame, only at the vertical-blank commit point.
//   clk_in, rst_n_in    : pixel clock, asynchronous active-low reset
//   gesture_valid_in    : pan step present
//   gesture_ready_out   : step can be accepted this cycle
//   gesture_dx_in/dy_in : signed steps
//   recenter_in         : force target to (0,0)
//   hcount_in/vcount_in : raster position
//   h_offset_out        : live horizontal offset
//   v_offset_out        : live vertical offset
//   moving_out          : live offset differs from target
//   state_dbg_out       : current FSM state (state_t encoding)
//
// Handshake: a step transfers on any cycle where gesture_valid_in and
// gesture_ready_out are both high; the producer holds valid and data stable
// until then. Ready is low during reset, on the first cycle after release,
// while recenter_in is high and during the single COMMIT cycle.
module pan_offset_controller
   import pan_pkg::*;
#(
   parameter int MAX_H_OFFSET = 1023,
   parameter int MAX_V_OFFSET = 511,
   parameter int STEP_MAX     = 8,
   parameter int COMMIT_LINE  = 720
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               gesture_valid_in,
   output logic               gesture_ready_out,
   input  logic [7:0]         gesture_dx_in,
   input  logic [7:0]         gesture_dy_in,
   input  logic               recenter_in,
   input  logic [10:0]        hcount_in,
   input  logic [9:0]         vcount_in,
   output logic [H_OFF_W-1:0] h_offset_out,
   output logic [V_OFF_W-1:0] v_offset_out,
   output logic               moving_out,
   output logic [1:0]         state_dbg_out
);

   state_t             state;
   logic               rdy_en;
   logic               hit;
   logic               hit_q;
   logic               frame_tick;
   logic               accept;
   logic               snap_en;
   logic               commit_en;
   logic               settled;
   logic [H_OFF_W-1:0] h_live_nxt;
   logic [H_OFF_W-1:0] h_tgt_nxt;
   logic [V_OFF_W-1:0] v_live_nxt;
   logic [V_OFF_W-1:0] v_tgt_nxt;

   assign hit               = (hcount_in == '0) && (vcount_in == 10'(COMMIT_LINE));
   // Rising edge only, so a raster that parks on the commit point still
   // yields a single tick per frame.
   assign frame_tick        = hit && !hit_q;
   assign gesture_ready_out = rdy_en && !recenter_in && (state != COMMIT);
   assign accept            = gesture_valid_in && gesture_ready_out;
   assign snap_en           = (state == SLEW) && frame_tick;
   assign commit_en         = (state == COMMIT);
   assign settled           = (h_live_nxt == h_tgt_nxt) && (v_live_nxt == v_tgt_nxt);
   assign state_dbg_out     = state;

   pan_axis #(
      .W        (H_OFF_W),
      .MAX_OFF  (MAX_H_OFFSET),
      .STEP_MAX (STEP_MAX)
   ) u_axis_h (
      .clk        (clk_in),
      .rst_n      (rst_n_in),
      .accept     (accept),
      .recenter   (recenter_in),
      .snap_en    (snap_en),
      .commit_en  (commit_en),
      .step       (gesture_dx_in),
      .live       (h_offset_out),
      .live_nxt   (h_live_nxt),
      .target_nxt (h_tgt_nxt)
   );

   pan_axis #(
      .W        (V_OFF_W),
      .MAX_OFF  (MAX_V_OFFSET),
      .STEP_MAX (STEP_MAX)
   ) u_axis_v (
      .clk        (clk_in),
      .rst_n      (rst_n_in),
      .accept     (accept),
      .recenter   (recenter_in),
      .snap_en    (snap_en),
      .commit_en  (commit_en),
      .step       (gesture_dy_in),
      .live       (v_offset_out),
      .live_nxt   (v_live_nxt),
      .target_nxt (v_tgt_nxt)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= IDLE;
         rdy_en     <= 1'b0;
         hit_q      <= 1'b0;
         moving_out <= 1'b0;
      end else begin
         rdy_en     <= 1'b1;
         hit_q      <= hit;
         moving_out <= !settled;
         case (state)
            // In IDLE live == target, so any difference comes from a new
            // step or a recenter taken this cycle.
            IDLE:    if (!settled) state <= SLEW;
            SLEW:    if (frame_tick) state <= COMMIT;
            COMMIT:  state <= settled ? IDLE : SLEW;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
